// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions: hazard FSM states, forward-select codes, register-index width.
package rv_pipe_pkg;

  localparam int unsigned REG_W = 5;

  // Operand source selects for the EX-stage ALU inputs.
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_EM = 2'b01;
  localparam logic [1:0] FWD_MW = 2'b10;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StLuWait = 2'd1,
    StHalt   = 2'd2
  } hz_state_e;

endpackage

// File: rtl/fwd_sel.sv
// Forwarding select for one EX operand: MEM-stage ALU result beats WB data beats regfile.
module fwd_sel
  import rv_pipe_pkg::*;
(
  input  logic [REG_W-1:0] rs_i,
  input  logic [REG_W-1:0] rd_em_i,
  input  logic             regwrite_em_i,
  input  logic [1:0]       memread_em_i,
  input  logic [REG_W-1:0] rd_mw_i,
  input  logic             regwrite_mw_i,
  output logic [1:0]       sel_o
);

  // A load in MEM has no data yet, so it is never a forwarding source.
  always_comb begin
    sel_o = FWD_RF;
    if (regwrite_em_i && (memread_em_i == 2'b00) && (rd_em_i != '0) && (rd_em_i == rs_i)) begin
      sel_o = FWD_EM;
    end else if (regwrite_mw_i && (rd_mw_i != '0) && (rd_mw_i == rs_i)) begin
      sel_o = FWD_MW;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I pipeline: forwarding selects, load-use bubbles,
// taken-branch flushes and debug halt. Define HAZARD_PERF_EN to add stall/flush counters.
module hazard_ctrl
  import rv_pipe_pkg::*;
#(
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [REG_W-1:0] RS1_FD,
  input  logic [REG_W-1:0] RS2_FD,
  input  logic             RS1_USE_FD,
  input  logic             RS2_USE_FD,
  input  logic [REG_W-1:0] RS1_DE,
  input  logic [REG_W-1:0] RS2_DE,
  input  logic [REG_W-1:0] RD_DE,
  input  logic             RegWrite_DE,
  input  logic [1:0]       MemRead_DE,
  input  logic [REG_W-1:0] RD_EM,
  input  logic             RegWrite_EM,
  input  logic [1:0]       MemRead_EM,
  input  logic [REG_W-1:0] RD_MW,
  input  logic             RegWrite_MW,
  input  logic             BR_TAKEN_E,
  input  logic             HALT_REQ,
  output logic             stall_FD,
  output logic             stall_DE,
  output logic             flush_FD,
  output logic             flush_DE,
  output logic             PC_STALL,
  output logic [1:0]       FWD_A_E,
  output logic [1:0]       FWD_B_E,
  output logic             HALTED
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT
`endif
);

  // Remaining LU_WAIT cycles after the first bubble, minus one.
  localparam logic [1:0] LuInit = (LOAD_LAT > 1) ? 2'(LOAD_LAT - 2) : 2'd0;

  hz_state_e  state_q, state_d;
  logic [1:0] lu_cnt_q, lu_cnt_d;
  logic       load_use;
  logic       bubble;   // hold IF/ID + PC, bubble ID/EX
  logic       br_flush;
  logic       halted;

  fwd_sel u_fwd_a (
    .rs_i          (RS1_DE),
    .rd_em_i       (RD_EM),
    .regwrite_em_i (RegWrite_EM),
    .memread_em_i  (MemRead_EM),
    .rd_mw_i       (RD_MW),
    .regwrite_mw_i (RegWrite_MW),
    .sel_o         (FWD_A_E)
  );

  fwd_sel u_fwd_b (
    .rs_i          (RS2_DE),
    .rd_em_i       (RD_EM),
    .regwrite_em_i (RegWrite_EM),
    .memread_em_i  (MemRead_EM),
    .rd_mw_i       (RD_MW),
    .regwrite_mw_i (RegWrite_MW),
    .sel_o         (FWD_B_E)
  );

  // Load in EX whose destination is read by the instruction in ID.
  always_comb begin
    load_use = (MemRead_DE != 2'b00) && RegWrite_DE && (RD_DE != '0) &&
               ((RS1_USE_FD && (RS1_FD == RD_DE)) || (RS2_USE_FD && (RS2_FD == RD_DE)));
  end

  // Next state and pipeline controls; a taken branch overrides every state.
  always_comb begin
    state_d  = state_q;
    lu_cnt_d = lu_cnt_q;
    bubble   = 1'b0;
    br_flush = 1'b0;
    halted   = 1'b0;
    if (BR_TAKEN_E) begin
      br_flush = 1'b1;
      state_d  = StRun;
      lu_cnt_d = 2'd0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (load_use) begin
            bubble = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d  = StLuWait;
              lu_cnt_d = LuInit;
            end
          end else if (HALT_REQ) begin
            bubble  = 1'b1;
            state_d = StHalt;
          end
        end
        StLuWait: begin
          bubble = 1'b1;
          if (lu_cnt_q == 2'd0) begin
            state_d = StRun;
          end else begin
            lu_cnt_d = lu_cnt_q - 2'd1;
          end
        end
        StHalt: begin
          // Release cycle is bubble-free: the pipeline is already drained.
          if (HALT_REQ) begin
            bubble = 1'b1;
            halted = 1'b1;
          end else begin
            state_d = StRun;
          end
        end
        default: begin
          state_d  = StRun;
          lu_cnt_d = 2'd0;
        end
      endcase
    end
  end

  // Output drive; ID/EX is never held since that would re-execute its instruction.
  always_comb begin
    stall_FD = bubble;
    PC_STALL = bubble;
    stall_DE = 1'b0;
    flush_FD = br_flush;
    flush_DE = bubble | br_flush;
    HALTED   = halted;
  end

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= StRun;
      lu_cnt_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Saturating stall/flush event counters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_FD && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_FD && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign STALL_CNT = stall_cnt_q;
  assign FLUSH_CNT = flush_cnt_q;
`endif

endmodule
